// File: rtl/nco_wave_gen_if.sv
// nco_wave_gen_if -- control and sample bus of the NCO waveform generator.
// The master side (stimulus/consumer) drives the advance enable and the
// waveform select; the slave side (the generator) returns the registered
// sample, the period-start pulse and the sticky select-hold error flag.
interface nco_wave_gen_if #(
  parameter int SELECT_WIDTH = 3,
  parameter int WAVE_WIDTH   = 8
);
  logic                    en;
  logic [SELECT_WIDTH-1:0] signal_out;
  logic [WAVE_WIDTH-1:0]   wave_out;
  logic                    period_start;
  logic                    hold_err;

  modport master (
    output en,
    output signal_out,
    input  wave_out,
    input  period_start,
    input  hold_err
  );

  modport slave (
    input  en,
    input  signal_out,
    output wave_out,
    output period_start,
    output hold_err
  );
endinterface

// File: rtl/nco_wave_gen.sv
// nco_wave_gen -- two-stage numerically controlled waveform generator.
//
// Stage 1 registers the waveform select and a phase counter; stage 2 turns
// (select, phase) into a registered unsigned sample. Every select change
// restarts the new waveform at phase 0, so a change is seen on wave_out two
// enabled cycles later as sample 0 of the new shape. en=0 freezes the whole
// pipeline and forces period_start low.
//
// Optional build macro: NCO_HOLD_CHECK_EN
//   defined   -> a 5-bit hold counter measures how long the select has been
//                stable; a change before it saturates sets the sticky
//                hold_err flag.
//   undefined -> no hold counter, hold_err is tied low.
//
// Reset is asynchronous and active-high and clears both control and the
// output sample, so nothing from before reset reaches wave_out afterwards.
module nco_wave_gen #(
  parameter int SELECT_WIDTH = 3,
  parameter int WAVE_WIDTH   = 8,
  parameter int PHASE_BITS   = 5
) (
  input  logic             clk,
  input  logic             reset,
  nco_wave_gen_if.slave    bus
);

  localparam int NSAMP    = 2 ** PHASE_BITS;
  localparam int HALF     = NSAMP / 2;
  localparam int QUARTER  = NSAMP / 4;
  localparam int SAW_STEP = (2 ** WAVE_WIDTH) / NSAMP;
  localparam int TRI_STEP = 2 * SAW_STEP;
  localparam logic [WAVE_WIDTH-1:0] WMAX = '1;

  typedef logic [PHASE_BITS-1:0]   phase_t;
  typedef logic [SELECT_WIDTH-1:0] sel_t;
  typedef logic [WAVE_WIDTH-1:0]   wave_t;

  // Pipeline state
  sel_t   sel_p1;
  phase_t ph_p1;
  logic   vld_p1;
  wave_t  wave_p2;
  logic   pstart_p2;

  logic   sel_chg;

  // ---------------------------------------------------------------------
  // Waveform arithmetic helpers
  // ---------------------------------------------------------------------

  // Clamp an integer into the unsigned sample range.
  function automatic wave_t sat_wave(input int v);
    if (v > int'(WMAX)) begin
      return WMAX;
    end else if (v < 0) begin
      return '0;
    end else begin
      return WAVE_WIDTH'(v);
    end
  endfunction

  // Keep only the low WAVE_WIDTH bits of an integer.
  function automatic wave_t trunc_wave(input int v);
    return WAVE_WIDTH'(v);
  endfunction

  // Quarter-wave symmetric sine, round(128 + 127*sin(2*pi*k/32)).
  function automatic logic [7:0] sine_tab(input logic [4:0] idx);
    logic [7:0] v;
    case (idx)
      5'd0:    v = 8'd128;
      5'd1:    v = 8'd153;
      5'd2:    v = 8'd177;
      5'd3:    v = 8'd199;
      5'd4:    v = 8'd218;
      5'd5:    v = 8'd234;
      5'd6:    v = 8'd245;
      5'd7:    v = 8'd253;
      5'd8:    v = 8'd255;
      5'd9:    v = 8'd253;
      5'd10:   v = 8'd245;
      5'd11:   v = 8'd234;
      5'd12:   v = 8'd218;
      5'd13:   v = 8'd199;
      5'd14:   v = 8'd177;
      5'd15:   v = 8'd153;
      5'd16:   v = 8'd128;
      5'd17:   v = 8'd103;
      5'd18:   v = 8'd79;
      5'd19:   v = 8'd57;
      5'd20:   v = 8'd38;
      5'd21:   v = 8'd22;
      5'd22:   v = 8'd11;
      5'd23:   v = 8'd3;
      5'd24:   v = 8'd1;
      5'd25:   v = 8'd3;
      5'd26:   v = 8'd11;
      5'd27:   v = 8'd22;
      5'd28:   v = 8'd38;
      5'd29:   v = 8'd57;
      5'd30:   v = 8'd79;
      default: v = 8'd103;
    endcase
    return v;
  endfunction

  // Sample for a given select and phase. Cosine reuses the sine table a
  // quarter period ahead.
  function automatic wave_t wave_lookup(input sel_t sel, input phase_t ph);
    int k;
    wave_t v;
    k = int'(ph);
    case (int'(sel))
      0:       v = WAVE_WIDTH'(sine_tab(5'(ph)));
      1:       v = WAVE_WIDTH'(sine_tab(5'(phase_t'(k + QUARTER))));
      2:       v = sat_wave((k < HALF) ? TRI_STEP * k : TRI_STEP * (NSAMP - k));
      3:       v = trunc_wave(SAW_STEP * k);
      4:       v = (k < HALF) ? WMAX : '0;
      5:       v = trunc_wave(int'(WMAX) - SAW_STEP * k);
      default: v = '0;
    endcase
    return v;
  endfunction

  assign sel_chg = (bus.signal_out != sel_p1);

  // ---------------------------------------------------------------------
  // Stage 1: capture select, advance or restart the phase
  // ---------------------------------------------------------------------

  // Phase restarts at 0 on a select change and on the first enabled cycle
  // after reset; otherwise it wraps through all NSAMP samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_p1 <= '0;
      ph_p1  <= '0;
      vld_p1 <= 1'b0;
    end else if (bus.en) begin
      sel_p1 <= bus.signal_out;
      vld_p1 <= 1'b1;
      if (sel_chg || !vld_p1) begin
        ph_p1 <= '0;
      end else begin
        ph_p1 <= ph_p1 + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: waveform lookup and period-start marker
  // ---------------------------------------------------------------------

  // Sample and its period marker move together; a stall drops the marker.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wave_p2   <= '0;
      pstart_p2 <= 1'b0;
    end else if (bus.en) begin
      if (vld_p1) begin
        wave_p2 <= wave_lookup(sel_p1, ph_p1);
      end
      pstart_p2 <= vld_p1 && (ph_p1 == '0);
    end else begin
      pstart_p2 <= 1'b0;
    end
  end

  assign bus.wave_out     = wave_p2;
  assign bus.period_start = pstart_p2;

`ifdef NCO_HOLD_CHECK_EN
  logic [4:0] hold_cnt_p1;
  logic       hold_err_q;

  // Select-stability counter; it starts saturated so the first change after
  // reset is always legal, and a change seen before saturation is latched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt_p1 <= 5'd31;
      hold_err_q  <= 1'b0;
    end else if (bus.en) begin
      if (sel_chg) begin
        hold_cnt_p1 <= 5'd0;
        if (hold_cnt_p1 != 5'd31) begin
          hold_err_q <= 1'b1;
        end
      end else if (hold_cnt_p1 != 5'd31) begin
        hold_cnt_p1 <= hold_cnt_p1 + 5'd1;
      end
    end
  end

  assign bus.hold_err = hold_err_q;
`else
  assign bus.hold_err = 1'b0;
`endif

endmodule
